// File: rtl/dma_channel_arbiter.sv
// Round-robin arbiter and burst sequencer sharing one DMA memory write port
// among NUM_CH requesting channels; one burst at a time, ack on completion.
module dma_channel_arbiter #(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_CH-1:0]          ch_req,
    input  logic [NUM_CH*ADDR_W-1:0]   ch_addr,
    input  logic [NUM_CH*LEN_W-1:0]    ch_len,
    input  logic [NUM_CH*DATA_W-1:0]   ch_data,
    output logic [NUM_CH-1:0]          ch_grant,
    output logic [NUM_CH-1:0]          ch_pop,
    output logic [NUM_CH-1:0]          ch_ack,
    output logic [ADDR_W-1:0]          mem_address,
    output logic [DATA_W-1:0]          mem_data_out,
    output logic                       mem_write_enable,
    input  logic                       mem_ready,
    output logic                       busy
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [IDX_W-1:0]   grant_idx_r;
    logic [IDX_W-1:0]   last_grant_r;
    logic [IDX_W-1:0]   sel_idx_s;
    logic               sel_valid_s;
    logic [LEN_W-1:0]   sel_len_s;
    logic [ADDR_W-1:0]  addr_r;
    logic [LEN_W-1:0]   len_r;
    logic [LEN_W-1:0]   beat_r;
    logic               accept_s;
    logic               last_beat_s;
    logic [NUM_CH-1:0]  grant_onehot_s;

    // Circular successor of a channel index; sum never exceeds 2*NUM_CH-1.
    function automatic logic [IDX_W-1:0] rr_index(input logic [IDX_W-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NUM_CH) begin
            sum = sum - NUM_CH;
        end else begin
            sum = sum;
        end
        return IDX_W'(sum);
    endfunction

    // Round-robin search starting just after the previously served channel.
    always_comb begin
        sel_valid_s = 1'b0;
        sel_idx_s   = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            if (!sel_valid_s && ch_req[rr_index(last_grant_r, k)]) begin
                sel_valid_s = 1'b1;
                sel_idx_s   = rr_index(last_grant_r, k);
            end else begin
                sel_idx_s   = sel_idx_s;
            end
        end
    end

    // A zero burst length is served as a single word.
    always_comb begin
        sel_len_s = ch_len[sel_idx_s*LEN_W +: LEN_W];
        if (sel_len_s == {LEN_W{1'b0}}) begin
            sel_len_s = LEN_W'(1);
        end else begin
            sel_len_s = sel_len_s;
        end
    end

    assign accept_s    = (state_r == XFER) && mem_ready;
    assign last_beat_s = (beat_r == (len_r - LEN_W'(1)));

    // Next-state logic for the IDLE -> XFER -> DONE burst sequence.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (sel_valid_s) begin
                    state_next_s = XFER;
                end else begin
                    state_next_s = IDLE;
                end
            end
            XFER: begin
                if (accept_s && last_beat_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = XFER;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Burst context: latched on grant, advanced per accepted beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_idx_r  <= '0;
            last_grant_r <= IDX_W'(NUM_CH - 1);
            addr_r       <= '0;
            len_r        <= '0;
            beat_r       <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (sel_valid_s) begin
                        grant_idx_r <= sel_idx_s;
                        addr_r      <= ch_addr[sel_idx_s*ADDR_W +: ADDR_W];
                        len_r       <= sel_len_s;
                        beat_r      <= '0;
                    end
                end
                XFER: begin
                    if (accept_s) begin
                        beat_r <= beat_r + LEN_W'(1);
                        addr_r <= addr_r + ADDR_W'(4);
                    end
                end
                DONE:    last_grant_r <= grant_idx_r;
                default: last_grant_r <= last_grant_r;
            endcase
        end
    end

    // One-hot decode of the latched grant index.
    always_comb begin
        grant_onehot_s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            grant_onehot_s[i] = (grant_idx_r == IDX_W'(i));
        end
    end

    assign ch_grant         = (state_r == XFER) ? grant_onehot_s : '0;
    assign ch_pop           = accept_s ? grant_onehot_s : '0;
    assign ch_ack           = (state_r == DONE) ? grant_onehot_s : '0;
    assign mem_write_enable = (state_r == XFER);
    assign mem_address      = (state_r == XFER) ? addr_r : '0;
    assign mem_data_out     = (state_r == XFER) ? ch_data[grant_idx_r*DATA_W +: DATA_W] : '0;
    assign busy             = (state_r != IDLE);

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// Directed self-checking bench for dma_channel_arbiter (4 channels, 32-bit).
module tb_dma_channel_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   ch_req;
    logic [127:0] ch_addr;
    logic [31:0]  ch_len;
    logic [127:0] ch_data;
    logic [3:0]   ch_grant;
    logic [3:0]   ch_pop;
    logic [3:0]   ch_ack;
    logic [31:0]  mem_address;
    logic [31:0]  mem_data_out;
    logic         mem_write_enable;
    logic         mem_ready;
    logic         busy;

    int           checks_cnt = 0;
    int           fail_cnt   = 0;
    int           pop_cnt[4];
    logic [31:0]  data_base[4];

    dma_channel_arbiter #(.NUM_CH(4), .ADDR_W(32), .DATA_W(32), .LEN_W(8)) dut (
        .clk(clk), .reset(reset), .ch_req(ch_req), .ch_addr(ch_addr), .ch_len(ch_len),
        .ch_data(ch_data), .ch_grant(ch_grant), .ch_pop(ch_pop), .ch_ack(ch_ack),
        .mem_address(mem_address), .mem_data_out(mem_data_out),
        .mem_write_enable(mem_write_enable), .mem_ready(mem_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] oh(input int c);
        logic [3:0] one;
        one = 4'b0001;
        return one << c;
    endfunction

    task automatic refresh_data();
        for (int i = 0; i < 4; i++) ch_data[i*32 +: 32] = data_base[i] + 32'(pop_cnt[i]);
    endtask

    // Channel model: present the next word after every observed pop.
    task automatic cycle();
        for (int i = 0; i < 4; i++) if (ch_pop[i]) pop_cnt[i]++;
        @(posedge clk);
        #1;
        refresh_data();
    endtask

    task automatic set_ch(input int i, input logic [31:0] a, input logic [7:0] l, input logic [31:0] d);
        ch_addr[i*32 +: 32] = a;
        ch_len[i*8 +: 8]    = l;
        data_base[i]        = d;
        pop_cnt[i]          = 0;
        refresh_data();
    endtask

    task automatic run_beat(input string tag, input int c, input logic [31:0] a,
                            input logic [31:0] d, input logic rdy);
        mem_ready = rdy;
        #1;
        check_value({tag, "_we"},    64'(mem_write_enable), 64'd1);
        check_value({tag, "_busy"},  64'(busy),             64'd1);
        check_value({tag, "_grant"}, 64'(ch_grant),         64'(oh(c)));
        check_value({tag, "_addr"},  64'(mem_address),      64'(a));
        check_value({tag, "_data"},  64'(mem_data_out),     64'(d));
        check_value({tag, "_pop"},   64'(ch_pop),           rdy ? 64'(oh(c)) : 64'd0);
        cycle();
    endtask

    task automatic check_done(input string tag, input int c);
        mem_ready = 1'b1;
        #1;
        check_value({tag, "_ack"},       64'(ch_ack),           64'(oh(c)));
        check_value({tag, "_ack_grant"}, 64'(ch_grant),         64'd0);
        check_value({tag, "_ack_we"},    64'(mem_write_enable), 64'd0);
        cycle();
        check_value({tag, "_idle_busy"}, 64'(busy),   64'd0);
        check_value({tag, "_idle_ack"},  64'(ch_ack), 64'd0);
    endtask

    initial begin
        logic [4:0] pat;
        int         e;
        int         order[5];
        reset     = 1'b1;
        ch_req    = 4'b0000;
        ch_addr   = '0;
        ch_len    = '0;
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data_base[i] = 32'h0;
            pop_cnt[i]   = 0;
        end
        refresh_data();
        cycle();
        cycle();
        check_value("rst_busy",  64'(busy),             64'd0);
        check_value("rst_we",    64'(mem_write_enable), 64'd0);
        check_value("rst_grant", 64'(ch_grant),         64'd0);
        check_value("rst_pop",   64'(ch_pop),           64'd0);
        check_value("rst_ack",   64'(ch_ack),           64'd0);
        check_value("rst_addr",  64'(mem_address),      64'd0);
        reset = 1'b0;

        // Single burst; request dropped during the burst must not abort it.
        set_ch(0, 32'h0000_0100, 8'd4, 32'h0000_00A0);
        ch_req = 4'b0001;
        cycle();
        ch_req = 4'b0000;
        for (int b = 0; b < 4; b++) run_beat("single", 0, 32'h100 + 32'(4*b), 32'hA0 + 32'(b), 1'b1);
        check_done("single", 0);
        check_value("single_pops", 64'(pop_cnt[0]), 64'd4);

        // Round robin from reset priority, all channels requesting, len 2.
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) set_ch(i, 32'h1000 * 32'(i + 1), 8'd2, 32'h10 * 32'(i));
        ch_req   = 4'b1111;
        order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0;
        for (int n = 0; n < 5; n++) begin
            int c;
            int v;
            c = order[n];
            v = (n == 4) ? 2 : 0;
            cycle();
            for (int b = 0; b < 2; b++)
                run_beat("rr", c, 32'h1000 * 32'(c + 1) + 32'(4*b), 32'h10 * 32'(c) + 32'(v + b), 1'b1);
            check_done("rr", c);
        end
        ch_req = 4'b0000;

        // Reset mid-burst: no ack, and priority returns to channel 0.
        set_ch(0, 32'h0000_0300, 8'd8, 32'h0000_0050);
        ch_req = 4'b0001;
        cycle();
        ch_req = 4'b0000;
        for (int b = 0; b < 3; b++) run_beat("mid", 0, 32'h300 + 32'(4*b), 32'h50 + 32'(b), 1'b1);
        mem_ready = 1'b1;
        #1;
        check_value("mid_pre_grant", 64'(ch_grant), 64'(4'b0001));
        reset = 1'b1;
        #1;
        check_value("mid_rst_we",    64'(mem_write_enable), 64'd0);
        check_value("mid_rst_grant", 64'(ch_grant),         64'd0);
        check_value("mid_rst_pop",   64'(ch_pop),           64'd0);
        check_value("mid_rst_ack",   64'(ch_ack),           64'd0);
        check_value("mid_rst_busy",  64'(busy),             64'd0);
        set_ch(0, 32'h0000_0300, 8'd8, 32'h0000_0050);
        set_ch(1, 32'h0000_0400, 8'd1, 32'h0000_0060);
        ch_req = 4'b0011;
        cycle();
        reset = 1'b0;
        #1;
        check_value("mid_rel_ack", 64'(ch_ack), 64'd0);
        cycle();
        ch_req = 4'b0000;
        for (int b = 0; b < 8; b++) run_beat("mid_again", 0, 32'h300 + 32'(4*b), 32'h50 + 32'(b), 1'b1);
        check_done("mid_again", 0);

        // Wait states: ready pattern 1,0,0,1,1 on a 3-word burst.
        set_ch(2, 32'h0000_0200, 8'd3, 32'h0000_00C0);
        ch_req = 4'b0100;
        cycle();
        ch_req = 4'b0000;
        pat = 5'b11001;
        e   = 0;
        for (int k = 0; k < 5; k++) begin
            run_beat("wait", 2, 32'h200 + 32'(4*e), 32'hC0 + 32'(e), pat[k]);
            if (pat[k]) e++;
        end
        check_done("wait", 2);
        check_value("wait_pops", 64'(pop_cnt[2]), 64'd3);

        // Address wrap across the top of the address space.
        set_ch(3, 32'hFFFF_FFFC, 8'd2, 32'h0000_00D0);
        ch_req = 4'b1000;
        cycle();
        ch_req = 4'b0000;
        run_beat("wrap", 3, 32'hFFFF_FFFC, 32'hD0, 1'b1);
        run_beat("wrap", 3, 32'h0000_0000, 32'hD1, 1'b1);
        check_done("wrap", 3);

        // Zero length serves exactly one word.
        set_ch(1, 32'h0000_0040, 8'd0, 32'h0000_00E0);
        ch_req = 4'b0010;
        cycle();
        ch_req = 4'b0000;
        run_beat("zero", 1, 32'h40, 32'hE0, 1'b1);
        check_done("zero", 1);
        check_value("zero_pops", 64'(pop_cnt[1]), 64'd1);
        cycle();
        cycle();
        check_value("noreq_busy", 64'(busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/dma_channel_arbiter.md
# dma_channel_arbiter

Round-robin arbiter and burst sequencer that shares the SoC's single DMA memory write port among `NUM_CH` requesting channels. Each channel raises a level request with a start address and burst length. The arbiter grants one channel at a time, streams that channel's data words to memory at consecutive word addresses, and returns a one-cycle completion acknowledge. It sits between the peripheral-side DMA requesters and the memory write interface.

## Interface
- `NUM_CH`, 4: number of requesting channels (2..8).
- `ADDR_W`, 32: memory byte-address width.
- `DATA_W`, 32: data word width.
- `LEN_W`, 8: burst-length field width per channel.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `ch_req`  in  NUM_CH  per-channel level request.
- `ch_addr`  in  NUM_CH*ADDR_W  packed start byte addresses, channel i at bits [i*ADDR_W +: ADDR_W].
- `ch_len`  in  NUM_CH*LEN_W  packed burst lengths in words; 0 is treated as 1.
- `ch_data`  in  NUM_CH*DATA_W  packed current data word per channel.
- `ch_grant`  out  NUM_CH  one-hot; high for the whole burst of the granted channel.
- `ch_pop`  out  NUM_CH  one-hot pulse; the granted channel's current word was accepted and the channel must present the next word.
- `ch_ack`  out  NUM_CH  one-hot, one-cycle pulse at burst completion.
- `mem_address`  out  ADDR_W  write address.
- `mem_data_out`  out  DATA_W  write data, a combinational mux of `ch_data` for the granted channel.
- `mem_write_enable`  out  1  write strobe.
- `mem_ready`  in  1  memory accepts the write this cycle.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- **States:** IDLE, XFER, DONE.
- **Reset values:** state IDLE, `last_grant` = NUM_CH-1 (so channel 0 has first priority), and all outputs 0.
- **IDLE:**
  - If any `ch_req` bit is set, select the first requesting channel, searching circularly from `last_grant+1`.
  - Latch the channel index, its `ch_addr`, and its length (0 maps to 1).
  - Clear the beat counter and go to XFER.
  - With no request, stay in IDLE.
- **XFER:**
  - `mem_write_enable` = 1.
  - `mem_address` = latched base + 4*beat, modulo 2^ADDR_W, so it wraps silently.
  - `ch_grant[g]` = 1.
  - A beat is accepted when `mem_ready` = 1. On acceptance, `ch_pop[g]` = 1 in that same cycle and beat increments.
  - When the accepted beat is the last one (beat = len-1), go to DONE.
  - `mem_ready` = 0 holds the address and data (wait state) with no pop.
- **DONE:**
  - `ch_ack[g]` = 1 and `ch_grant` = 0.
  - `last_grant` ← g, then go to IDLE.
- **Changes during a burst:** `ch_req`, `ch_addr` and `ch_len` changes during XFER are ignored. A burst always runs to completion; deasserting the request does not abort it.
- **Re-requesting:** a channel still requesting after its ack is re-served only after every other requesting channel has had a turn.
- **Reset mid-burst:** reset asynchronously returns to IDLE and drops `mem_write_enable`, grant, pop and ack immediately. No ack is issued for the aborted burst.
- **Output sourcing:** `mem_address`, `mem_write_enable`, `ch_grant`, `ch_ack`, `busy` and `ch_pop` are derived only from registered state and `mem_ready`. None depends combinationally on `ch_req`.

## Timing
- **Grant latency:** a request present at edge E (state IDLE) gives grant and write enable in the cycle after E.
- **Burst length:** with `mem_ready` held high, a burst of L words occupies L XFER cycles, then 1 DONE cycle, then 1 IDLE cycle.
- **Back-to-back spacing:** first write of the next burst is L+2 cycles after the first write of the previous burst.
- **Wait states:** each `mem_ready`=0 cycle in XFER adds exactly one cycle.
- **Ack timing:** `ch_ack` is exactly one cycle wide and occurs the cycle after the last accepted beat.
- **Pops:** exactly len (min 1) pops per burst.

## Test plan
- **Single burst:** channel 0 requests, addr 0x100, len 4, data incrementing 0xA0..0xA3 on each pop, `mem_ready`=1 → writes to 0x100, 0x104, 0x108, 0x10C with data A0..A3, 4 pops, `ch_ack[0]` one cycle later, `busy` low after.
- **Round-robin:** all four channels request continuously, len 2 → grant order 0,1,2,3,0; each grant 2 write cycles, then 2 idle-overhead cycles before the next grant.
- **Wait states:** channel 2, len 3, `mem_ready` pattern 1,0,0,1,1 → address and data held during the 0 cycles, 3 pops, ack after the 5th XFER cycle.
- **Zero length:** channel 1 with `ch_len`=0, addr 0x40 → exactly one write to 0x40, one pop, one ack.
- **Address wrap:** channel 3, addr 0xFFFFFFFC, len 2 → writes to 0xFFFFFFFC then 0x00000000.
- **Reset mid-burst:** channel 0, len 8; assert reset after beat 3 → outputs drop at once, no ack; after release with channel 1 requesting, channel 0 and channel 1 both requesting → channel 0 is granted first (reset priority).
